note_draw_controller: RTL and testbench

//  Sequencer for the note-highway datapath (240x180 grid at screen y=60, 3 rows x 4 boxes of 60x60).

---
 rtl/theremin_pkg.sv | 25 ++
 rtl/note_draw_controller_if.sv | 39 +++
 rtl/beat_timer.sv | 24 ++
 rtl/note_draw_controller.sv | 189 ++++++++++++++++++
 tb/tb_note_draw_controller.sv | 162 ++++++++++++++++
 5 files changed

// File: rtl/theremin_pkg.sv
// rtl/theremin_pkg.sv - shared states and geometry/latency constants for the note highway
package theremin_pkg;

  typedef enum logic [3:0] {
    S_IDLE,
    S_DEF_DRAW,
    S_DEF_DRAIN,
    S_BEAT_WAIT,
    S_SHIFT,
    S_BOX_SETUP,
    S_BOX_DRAW,
    S_BOX_DRAIN,
    S_DONE
  } state_t;

  localparam int GRID_W      = 240;
  localparam int GRID_H      = 180;
  localparam int BOX_SIZE    = 60;
  localparam int NUM_BOXES   = 12;
  localparam int BEAT_CYCLES = 12500000;
  localparam int SONG_STEPS  = 112;
  localparam int DEF_LAT     = 3;
  localparam int BOX_LAT     = 3;

endpackage

// File: rtl/note_draw_controller_if.sv
// rtl/note_draw_controller_if.sv - strobe/counter bundle between controller and datapath (optional PAUSE_EN adds pause)
interface note_draw_controller_if;
  logic        start;
`ifdef PAUSE_EN
  logic        pause;
`endif
  logic        shiftSong;
  logic        songDone;
  logic        loadDefault;
  logic        writeDefault;
  logic        loadX;
  logic        loadY;
  logic        writeToScreen;
  logic [15:0] gridCounter;
  logic [3:0]  boxCounter;
  logic [14:0] pixelCount;
  logic        plot;
  logic        busy;

  // controller side
  modport master (
    input  start,
`ifdef PAUSE_EN
    input  pause,
`endif
    output shiftSong, songDone, loadDefault, writeDefault, loadX, loadY,
           writeToScreen, gridCounter, boxCounter, pixelCount, plot, busy
  );

  // game FSM / datapath side
  modport slave (
    output start,
`ifdef PAUSE_EN
    output pause,
`endif
    input  shiftSong, songDone, loadDefault, writeDefault, loadX, loadY,
           writeToScreen, gridCounter, boxCounter, pixelCount, plot, busy
  );
endinterface

// File: rtl/beat_timer.sv
// rtl/beat_timer.sv - beat period counter with enable, clear and terminal-count tick
module beat_timer #(
  parameter int CYCLES = 12500000
) (
  input  logic clock,
  input  logic resetn,
  input  logic enable,
  input  logic clear,
  output logic tick
);
  localparam int W = $clog2(CYCLES);
  localparam logic [W-1:0] LAST = W'(CYCLES - 1);

  logic [W-1:0] count;

  assign tick = enable && (count == LAST);

  // count enabled cycles; restart on clear or after the tick
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn)             count <= '0;
    else if (clear || tick)  count <= '0;
    else if (enable)         count <= count + 1'b1;
  end
endmodule

// File: rtl/note_draw_controller.sv
// rtl/note_draw_controller.sv - note-highway draw sequencer (optional PAUSE_EN macro adds beat pause)
module note_draw_controller #(
  parameter int GRID_W      = theremin_pkg::GRID_W,
  parameter int GRID_H      = theremin_pkg::GRID_H,
  parameter int BOX_SIZE    = theremin_pkg::BOX_SIZE,
  parameter int NUM_BOXES   = theremin_pkg::NUM_BOXES,
  parameter int BEAT_CYCLES = theremin_pkg::BEAT_CYCLES,
  parameter int SONG_STEPS  = theremin_pkg::SONG_STEPS,
  parameter int DEF_LAT     = theremin_pkg::DEF_LAT,
  parameter int BOX_LAT     = theremin_pkg::BOX_LAT
) (
  input logic              clock,
  input logic              resetn,
  note_draw_controller_if.master bus
);
  import theremin_pkg::*;

  localparam int STEP_W = $clog2(SONG_STEPS + 1);
  localparam logic [7:0]        GX_LAST   = 8'(GRID_W - 1);
  localparam logic [7:0]        GY_LAST   = 8'(GRID_H - 1);
  localparam logic [7:0]        PX_LAST   = 8'(BOX_SIZE - 1);
  localparam logic [6:0]        PY_LAST   = 7'(BOX_SIZE - 1);
  localparam logic [3:0]        BOX_LAST  = 4'(NUM_BOXES);
  localparam logic [3:0]        DEF_DLAST = 4'(DEF_LAT - 1);
  localparam logic [3:0]        BOX_DLAST = 4'(BOX_LAT - 1);
  localparam logic [STEP_W-1:0] STEP_LAST = STEP_W'(SONG_STEPS);

  state_t              state, state_next;
  logic [7:0]          gx, gy, px;
  logic [6:0]          py;
  logic [3:0]          box;
  logic [3:0]          drain_cnt;
  logic [STEP_W-1:0]   step;
  logic [DEF_LAT-1:0]  def_pipe;
  logic [BOX_LAT-1:0]  box_pipe;
  logic                beat_run, beat_tick;
  logic                grid_last, pix_last, box_last, drain_done, song_last;

  assign grid_last  = (gx == GX_LAST) && (gy == GY_LAST);
  assign pix_last   = (px == PX_LAST) && (py == PY_LAST);
  assign box_last   = (box == BOX_LAST);
  assign drain_done = (drain_cnt == ((state == S_DEF_DRAIN) ? DEF_DLAST : BOX_DLAST));
  assign song_last  = ((step + 1'b1) == STEP_LAST);

`ifdef PAUSE_EN
  logic pause_pending;

  // remember pause requests seen mid-frame so they only take effect once the frame is finished
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn)                   pause_pending <= 1'b0;
    else if (state == S_BEAT_WAIT) pause_pending <= 1'b0;
    else if (bus.pause)            pause_pending <= 1'b1;
  end

  assign beat_run = (state == S_BEAT_WAIT) && !bus.pause && !pause_pending;
`else
  assign beat_run = (state == S_BEAT_WAIT);
`endif

  beat_timer #(.CYCLES(BEAT_CYCLES)) u_beat (
    .clock  (clock),
    .resetn (resetn),
    .enable (beat_run),
    .clear  (state != S_BEAT_WAIT),
    .tick   (beat_tick)
  );

  // state register
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) state <= S_IDLE;
    else         state <= state_next;
  end

  // next-state decode
  always_comb begin
    state_next = state;
    case (state)
      S_IDLE:      if (bus.start)  state_next = S_DEF_DRAW;
      S_DEF_DRAW:  if (grid_last)  state_next = S_DEF_DRAIN;
      S_DEF_DRAIN: if (drain_done) state_next = S_BEAT_WAIT;
      S_BEAT_WAIT: if (beat_tick)  state_next = S_SHIFT;
      S_SHIFT:                     state_next = S_BOX_SETUP;
      S_BOX_SETUP:                 state_next = S_BOX_DRAW;
      S_BOX_DRAW:  if (pix_last)   state_next = box_last ? S_BOX_DRAIN : S_BOX_SETUP;
      S_BOX_DRAIN: if (drain_done) state_next = song_last ? S_DONE : S_BEAT_WAIT;
      S_DONE:                      state_next = S_IDLE;
      default:                     state_next = S_IDLE;
    endcase
  end

  // strobe decode; writeToScreen spans setup so late box plots stay on the box path
  always_comb begin
    bus.shiftSong     = (state == S_SHIFT);
    bus.songDone      = (state == S_DONE);
    bus.loadDefault   = (state == S_DEF_DRAW);
    bus.writeDefault  = (state == S_DEF_DRAW) || (state == S_DEF_DRAIN);
    bus.loadX         = (state == S_BOX_DRAW);
    bus.loadY         = (state == S_BOX_DRAW);
    bus.writeToScreen = (state == S_BOX_SETUP) || (state == S_BOX_DRAW) || (state == S_BOX_DRAIN);
    bus.busy          = (state != S_IDLE);
  end

  assign bus.gridCounter = {gx, gy};
  assign bus.pixelCount  = {px, py};
  assign bus.boxCounter  = box;
  assign bus.plot        = def_pipe[DEF_LAT-1] | box_pipe[BOX_LAT-1];

  // background scan, y fastest, holds at the last pixel through the drain
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      gx <= '0;
      gy <= '0;
    end else if (state == S_IDLE) begin
      gx <= '0;
      gy <= '0;
    end else if ((state == S_DEF_DRAW) && !grid_last) begin
      if (gy == GY_LAST) begin
        gy <= '0;
        gx <= gx + 8'd1;
      end else begin
        gy <= gy + 8'd1;
      end
    end
  end

  // box number and in-box pixel scan
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      box <= '0;
      px  <= '0;
      py  <= '0;
    end else begin
      case (state)
        S_SHIFT: begin
          box <= 4'd1;
          px  <= '0;
          py  <= '0;
        end
        S_BOX_SETUP: ;
        S_BOX_DRAW: begin
          if (pix_last) begin
            px <= '0;
            py <= '0;
            if (!box_last) box <= box + 4'd1;
          end else if (py == PY_LAST) begin
            py <= '0;
            px <= px + 8'd1;
          end else begin
            py <= py + 7'd1;
          end
        end
        S_BOX_DRAIN: if (drain_done) box <= '0;
        default: begin
          box <= '0;
          px  <= '0;
          py  <= '0;
        end
      endcase
    end
  end

  // drain length counter shared by both drain states
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn)
      drain_cnt <= '0;
    else if (((state == S_DEF_DRAIN) || (state == S_BOX_DRAIN)) && !drain_done)
      drain_cnt <= drain_cnt + 4'd1;
    else
      drain_cnt <= '0;
  end

  // completed redraws in this song
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn)                                  step <= '0;
    else if (state == S_DONE)                     step <= '0;
    else if ((state == S_BOX_DRAIN) && drain_done) step <= step + 1'b1;
  end

  // per-path valid pipes aligning plot with datapath output
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      def_pipe <= '0;
      box_pipe <= '0;
    end else begin
      def_pipe <= (def_pipe << 1) | DEF_LAT'(state == S_DEF_DRAW);
      box_pipe <= (box_pipe << 1) | BOX_LAT'(state == S_BOX_DRAW);
    end
  end
endmodule

// File: tb/tb_note_draw_controller.sv
// tb/tb_note_draw_controller.sv - directed bench for note_draw_controller at reduced geometry
module tb_note_draw_controller;
  logic clock;
  logic resetn;
  int   tests = 0;
  int   fails = 0;

  note_draw_controller_if bus_if ();

  note_draw_controller #(
    .GRID_W(4), .GRID_H(3), .BOX_SIZE(2), .NUM_BOXES(12),
    .BEAT_CYCLES(20), .SONG_STEPS(2), .DEF_LAT(3), .BOX_LAT(3)
  ) dut (
    .clock  (clock),
    .resetn (resetn),
    .bus    (bus_if)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [8:0] strobes();
    return {bus_if.shiftSong, bus_if.songDone, bus_if.loadDefault, bus_if.writeDefault,
            bus_if.loadX, bus_if.loadY, bus_if.writeToScreen, bus_if.plot, bus_if.busy};
  endfunction

  int ld_cnt, first_ld, first_plot, def_plots, box_plots, box_plots1, stray, overlap;
  int shift_cnt, done_cnt, done_cyc;
  int shift_cyc [4];
  logic [14:0] exp_pix [4];
  bit found;
  int post_plot, post_busy;

  initial begin
    exp_pix[0] = 15'h0000; exp_pix[1] = 15'h0001; exp_pix[2] = 15'h0080; exp_pix[3] = 15'h0081;
    resetn = 1'b0;
    bus_if.start = 1'b0;
`ifdef PAUSE_EN
    bus_if.pause = 1'b0;
`endif
    @(negedge clock);
    @(negedge clock);
    check("reset_strobes", 32'(strobes()), 32'h0);
    check("reset_grid", 32'(bus_if.gridCounter), 32'h0);
    check("reset_box", 32'(bus_if.boxCounter), 32'h0);
    check("reset_pix", 32'(bus_if.pixelCount), 32'h0);
    resetn = 1'b1;
    @(negedge clock);
    check("idle_busy", 32'(bus_if.busy), 32'h0);

    // one full song; a start pulse is injected while busy at cycle 50
    ld_cnt = 0; first_ld = -1; first_plot = -1; def_plots = 0; box_plots = 0; box_plots1 = 0;
    stray = 0; overlap = 0; shift_cnt = 0; done_cnt = 0; done_cyc = -1;
    bus_if.start = 1'b1;
    for (int c = 0; c < 190; c++) begin
      @(negedge clock);
      bus_if.start = (c == 50);
      if (bus_if.loadDefault) begin
        check("grid_seq", 32'(bus_if.gridCounter), 32'({8'(ld_cnt / 3), 8'(ld_cnt % 3)}));
        if (first_ld < 0) first_ld = c;
        ld_cnt++;
      end
      if (bus_if.plot && first_plot < 0) first_plot = c;
      if (bus_if.plot && bus_if.writeDefault) def_plots++;
      if (bus_if.plot && bus_if.writeToScreen) begin
        box_plots++;
        if (c <= 98) box_plots1++;
      end
      if (bus_if.plot && !bus_if.writeDefault && !bus_if.writeToScreen) stray++;
      if (bus_if.writeDefault && bus_if.writeToScreen) overlap++;
      if (bus_if.shiftSong) begin
        if (shift_cnt < 4) shift_cyc[shift_cnt] = c;
        shift_cnt++;
      end
      if (bus_if.songDone) begin
        done_cnt++;
        done_cyc = c;
      end
      if (c >= 36 && c <= 91 && ((c - 36) % 5) == 0)
        check("box_num", 32'(bus_if.boxCounter), 32'((c - 36) / 5 + 1));
      if (c >= 37 && c <= 40) begin
        check("pix_seq", 32'(bus_if.pixelCount), 32'(exp_pix[c - 37]));
        check("load_xy", 32'({bus_if.loadX, bus_if.loadY}), 32'h3);
      end
      if (c == 34) check("box_zero_wait", 32'(bus_if.boxCounter), 32'h0);
      if (c == 100) check("busy_mid", 32'(bus_if.busy), 32'h1);
    end
    check("ld_count", 32'(ld_cnt), 32'd12);
    check("first_ld", 32'(first_ld), 32'd0);
    check("first_plot", 32'(first_plot), 32'd3);
    check("def_plots", 32'(def_plots), 32'd12);
    check("box_plots_redraw1", 32'(box_plots1), 32'd48);
    check("box_plots_song", 32'(box_plots), 32'd96);
    check("stray_plot", 32'(stray), 32'd0);
    check("path_overlap", 32'(overlap), 32'd0);
    check("shift_count", 32'(shift_cnt), 32'd2);
    check("shift1_cycle", 32'(shift_cyc[0]), 32'd35);
    check("shift2_cycle", 32'(shift_cyc[1]), 32'd119);
    check("done_count", 32'(done_cnt), 32'd1);
    check("done_cycle", 32'(done_cyc), 32'd183);
    check("end_busy", 32'(bus_if.busy), 32'h0);
    check("end_box", 32'(bus_if.boxCounter), 32'h0);

    // reset in the middle of box 5
    found = 1'b0;
    bus_if.start = 1'b1;
    for (int i = 0; i < 200; i++) begin
      @(negedge clock);
      bus_if.start = 1'b0;
      if (bus_if.boxCounter == 4'd5 && bus_if.loadX && bus_if.pixelCount == 15'h0001) begin
        found = 1'b1;
        break;
      end
    end
    check("reach_box5", 32'(found), 32'h1);
    resetn = 1'b0;
    #1;
    check("midrst_strobes", 32'(strobes()), 32'h0);
    check("midrst_box", 32'(bus_if.boxCounter), 32'h0);
    check("midrst_pix", 32'(bus_if.pixelCount), 32'h0);
    @(negedge clock);
    resetn = 1'b1;
    post_plot = 0; post_busy = 0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clock);
      if (bus_if.plot) post_plot++;
      if (bus_if.busy) post_busy++;
    end
    check("post_rst_plot", 32'(post_plot), 32'd0);
    check("post_rst_busy", 32'(post_busy), 32'd0);

`ifdef PAUSE_EN
    // pause for 10 cycles inside the first beat wait
    shift_cnt = 0;
    shift_cyc[0] = -1;
    bus_if.start = 1'b1;
    for (int c = 0; c < 60; c++) begin
      @(negedge clock);
      bus_if.start = 1'b0;
      bus_if.pause = (c >= 20 && c < 30);
      if (bus_if.shiftSong) begin
        if (shift_cnt < 4) shift_cyc[shift_cnt] = c;
        shift_cnt++;
      end
    end
    bus_if.pause = 1'b0;
    check("pause_shift_count", 32'(shift_cnt), 32'd1);
    check("pause_shift_cycle", 32'(shift_cyc[0]), 32'd45);
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
